// File: rtl/load_handler_pkg.sv
// Shared core definitions: funct3 encodings for loads/stores and the load FSM state encoding.
package load_handler_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_READ  = 2'd1,
    LD_DONE  = 2'd2,
    LD_FAULT = 2'd3
  } ld_state_e;

  // Undefined funct3 codes behave as LW for data but are never flagged misaligned.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_LH, F3_LHU: mis = off[0];
      F3_LW:         mis = (off != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
module load_extract
  import load_handler_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  // offset[0] is deliberately ignored for halfwords; a trapping build never reaches here misaligned.
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_handler.sv
// Sequenced RV32I load unit: one aligned word read per request, extract/extend, one-cycle result pulse.
// Define LOAD_MISALIGN_TRAP_EN to route misaligned LH/LHU/LW to a fault pulse instead of a read.
module load_handler
  import load_handler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        load_fault
);

  ld_state_e   state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] ext;
  logic        accept;
  logic        misalign;

  assign accept = req_valid && (state == LD_IDLE);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_addr[1:0], req_funct3);
`else
  assign misalign = 1'b0;
`endif

  load_extract u_extract (
    .word   (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .result (ext)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (req_valid) state_nxt = misalign ? LD_FAULT : LD_READ;
      LD_READ:  if (mem_ack) state_nxt = LD_DONE;
      LD_DONE:  state_nxt = LD_IDLE;
      LD_FAULT: state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 32'h0;
      f3_q   <= 3'h0;
    end else if (accept) begin
      addr_q <= req_addr;
      f3_q   <= req_funct3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             rd_data <= 32'h0;
    else if (state == LD_READ && mem_ack)  rd_data <= ext;
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  assign req_ready = (state == LD_IDLE);
  assign mem_rd    = (state == LD_READ);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rd_valid  = (state == LD_DONE);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign load_fault = (state == LD_FAULT);
`else
  assign load_fault = 1'b0;
`endif

endmodule

// File: doc/load_handler.md
# load_handler

Sequenced load unit for the multicycle RV32I core; the read-side counterpart of the store read-modify-write path. It accepts a load request from the control unit and issues one aligned word read to data memory. It then waits for the memory acknowledge, extracts the addressed byte, halfword or word, and sign- or zero-extends it. It returns the result to the register-file write-back path with a one-cycle valid pulse.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  control unit requests a load.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_addr`  in  32  effective byte address (rs1 + imm).
- `req_funct3`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_addr`  out  32  word-aligned read address `{addr_q[31:2],2'b00}`.
- `mem_rd`  out  1  read strobe; held high until `mem_ack`.
- `mem_rdata`  in  32  memory word; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  memory read complete; any latency ≥0 cycles after `mem_rd` rises.
- `rd_data`  out  32  extended load result.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid while it is high.
- `load_fault`  out  1  one-cycle pulse on a misaligned access. Only present in behaviour when `LOAD_MISALIGN_TRAP_EN` is defined; otherwise tied to 0.

## Operation
- States are IDLE, READ, DONE and FAULT.
- **IDLE:** `req_ready`=1. On accept, capture `req_addr` into `addr_q` and `req_funct3` into `f3_q`, then go to READ.
  - With `LOAD_MISALIGN_TRAP_EN` defined, an accepted misaligned request goes to FAULT instead.
  - Misaligned means `addr[0]`=1 for LH/LHU, or `addr[1:0]`≠00 for LW.
- **READ:** `mem_rd`=1 with `mem_addr` stable. When `mem_ack` is high, register the extracted result into `rd_data` and go to DONE.
- **DONE:** `rd_valid`=1 for exactly one cycle, then return to IDLE.
- **FAULT:** `load_fault`=1 for one cycle, no memory access, `rd_data` unchanged, then return to IDLE.
- Lane select for bytes: `offset = addr_q[1:0]`, byte = `word[8*offset+7 : 8*offset]`.
- Lane select for halfwords: `addr_q[1]` chooses the half, `word[16*h+15 : 16*h]`. Without the macro, `addr_q[0]` is ignored.
- Extension rules:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through; without the macro, `addr_q[1:0]` is ignored.
- Undefined funct3 values (011, 110, 111) are treated as LW. They never fault.
- `mem_ack` outside READ is ignored.
- `req_valid` outside IDLE is ignored; no queuing.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `mem_rd`=0, `mem_addr`=0, `rd_data`=0, `rd_valid`=0, `load_fault`=0, `addr_q`=0, `f3_q`=0.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronously). The in-flight load is dropped and no `rd_valid` is produced.
- Accept on edge N puts the block in READ from cycle N+1. If `mem_ack` arrives in cycle N+1, `rd_valid` is high in cycle N+2. Minimum latency is 2 cycles from accept to result.
- Each wait cycle on `mem_ack` adds 1 cycle of latency.
- `mem_rd` falls the cycle after `mem_ack`.
- `req_ready` returns high in the cycle after DONE or FAULT. Back-to-back loads therefore have a throughput of one load per 3 cycles at best.
- `rd_data` holds its value until the next DONE.
- Fault path: accept on edge N gives `load_fault` high in cycle N+1, and IDLE in cycle N+2.

## Configuration
- `LOAD_MISALIGN_TRAP_EN` defined: misaligned LH/LHU/LW are detected at accept and routed to FAULT. No memory read is issued.
- Not defined:
  - Misalignment is silently tolerated by ignoring the offending low address bits.
  - The FAULT state is unreachable and `load_fault` is constant 0.

## Structure
- The shared core package holds:
  - funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, plus `F3_SB`/`F3_SH`/`F3_SW` shared with the store side);
  - the load FSM state encoding.
- One combinational sub-module, `load_extract`, takes (word, offset, funct3) and produces the extended value. It is reusable and unit-testable on its own.
- The FSM and the registers live in `load_handler`.

## Test plan
- LB at offset 3, `mem_rdata`=32'h80FF_1234 with ack 0-wait → `rd_data`=32'hFFFF_FF80, `rd_valid` in cycle N+2.
- LBU at offset 1, same word → 32'h0000_0012.
- LHU at `addr[1]`=1, word 32'h8001_7FFF → 32'h0000_8001. LH with `addr[1]`=0 on the same word → 32'h0000_7FFF.
- LW at address 0x100 with `mem_ack` delayed 3 cycles:
  - `mem_addr`=0x100 and `mem_rd` held for 4 cycles;
  - `rd_valid` in cycle N+5 with `rd_data`=`mem_rdata`.
- LH at address 0x101:
  - with the macro: `load_fault` pulse in N+1, `mem_rd` never rises;
  - without the macro: reads the lower half.
- `reset` asserted while in READ → `mem_rd` drops immediately and no `rd_valid` follows. A new LW after release completes normally.
